instruction_memory_pipelined: RTL

Parametrised, byte-addressed, little-endian instruction memory with a registered read port and a program-load write port. It is the next generation of the combinational instruction ROM and sits between the PC/fetch stage and decode. It adds the following:
- valid/ready fetch handshake with one-cycle latency and output hold under stall.
- runtime byte-masked program loading.
- alignment/range fault reporting.

---
 rtl/instruction_memory_pipelined.sv | 130 +++++++++++++
 1 files changed

// File: rtl/instruction_memory_pipelined.sv
// ----------------------------------------------------------------------------
// instruction_memory_pipelined
//
// Byte-addressed, little-endian instruction memory with a registered,
// valid/ready fetch port and a byte-masked program-load port.
//
// Ports:
//   clk, reset_n          clock and asynchronous active-low reset
//   req_valid/req_ready   fetch request handshake (req_ready is combinational)
//   req_addr              byte address of the instruction to fetch
//   resp_valid/ready      response handshake; outputs hold while stalled
//   resp_inst             {mem[a+3], mem[a+2], mem[a+1], mem[a]} or NOP_INST
//   resp_fault            fetch address was misaligned or out of range
//   load_en/addr/data/be  program-load write port, one 32-bit word per edge
//   load_err              one-cycle pulse after a rejected load
//   fetch_count           accepted fetch requests, wraps at 2^32
// ----------------------------------------------------------------------------
module instruction_memory_pipelined #(
    parameter int unsigned           ADDR_WIDTH  = 64,
    parameter int unsigned           DEPTH_BYTES = 256,
    parameter int unsigned           INST_WIDTH  = 32,
    parameter logic [INST_WIDTH-1:0] NOP_INST    = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [INST_WIDTH-1:0] resp_inst,
    output logic                  resp_fault,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [31:0]           load_data,
    input  logic [3:0]            load_be,
    output logic                  load_err,
    output logic [31:0]           fetch_count
);

    localparam int unsigned IDX_W  = $clog2(DEPTH_BYTES);
    localparam int unsigned WORD_W = IDX_W - 2;
    // Highest legal word address, compared at full address width so that
    // large addresses never alias into the array.
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(DEPTH_BYTES - 4);

    // Contents start at zero and are deliberately left out of reset.
    logic [7:0] mem_q [DEPTH_BYTES] = '{default: '0};

    logic                  resp_valid_q, resp_valid_d;
    logic [INST_WIDTH-1:0] resp_inst_q,  resp_inst_d;
    logic                  resp_fault_q, resp_fault_d;
    logic                  load_err_q,   load_err_d;
    logic [31:0]           fetch_count_q, fetch_count_d;

    logic              accept;
    logic              req_fault;
    logic              load_fault;
    logic [WORD_W-1:0] req_word;
    logic [WORD_W-1:0] load_word;
    logic [31:0]       rd_word;
    logic [3:0]        wr_be;

    function automatic logic addr_fault(input logic [ADDR_WIDTH-1:0] a);
        return (a[1:0] != 2'b00) || (a > LAST_WORD);
    endfunction

    assign req_ready = !resp_valid_q || resp_ready;
    assign accept    = req_valid && req_ready;

    always_comb begin
        req_fault  = addr_fault(req_addr);
        load_fault = addr_fault(load_addr);
        // Faulting addresses are steered to word 0 so the array is never
        // indexed with an unchecked address; the data is discarded anyway.
        req_word   = req_fault  ? '0 : req_addr[IDX_W-1:2];
        load_word  = load_fault ? '0 : load_addr[IDX_W-1:2];
        rd_word    = {mem_q[{req_word, 2'd3}], mem_q[{req_word, 2'd2}],
                      mem_q[{req_word, 2'd1}], mem_q[{req_word, 2'd0}]};
        wr_be      = (load_en && !load_fault) ? load_be : 4'b0000;
    end

    always_comb begin
        resp_valid_d  = resp_valid_q;
        resp_inst_d   = resp_inst_q;
        resp_fault_d  = resp_fault_q;
        fetch_count_d = fetch_count_q;
        if (accept) begin
            resp_valid_d  = 1'b1;
            resp_fault_d  = req_fault;
            resp_inst_d   = req_fault ? NOP_INST : rd_word;
            fetch_count_d = fetch_count_q + 32'd1;
        end else if (resp_ready) begin
            resp_valid_d  = 1'b0;
        end
        load_err_d = load_en && load_fault;
    end

    // The array shares this block with the reset flops so that loads are
    // suppressed while reset is asserted; the reset branch leaves it alone.
    // Reading rd_word (old contents) in the same edge as the write gives
    // read-before-write for same-word fetch/load collisions.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_valid_q  <= 1'b0;
            resp_inst_q   <= NOP_INST;
            resp_fault_q  <= 1'b0;
            load_err_q    <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            resp_valid_q  <= resp_valid_d;
            resp_inst_q   <= resp_inst_d;
            resp_fault_q  <= resp_fault_d;
            load_err_q    <= load_err_d;
            fetch_count_q <= fetch_count_d;
            for (int unsigned k = 0; k < 4; k++) begin
                if (wr_be[k]) begin
                    mem_q[{load_word, 2'(k)}] <= load_data[8*k +: 8];
                end
            end
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_inst   = resp_inst_q;
    assign resp_fault  = resp_fault_q;
    assign load_err    = load_err_q;
    assign fetch_count = fetch_count_q;

endmodule
